// File: rtl/m_fetch.sv
// m_fetch: instruction-fetch stage owning the PC, one outstanding imem
// request and a 2-entry {inst, pc} queue feeding the execute stage.
module m_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_AW  = 6
) (
    input  logic               w_clk,
    input  logic               w_rst,
    output logic               w_imem_en,
    output logic [IMEM_AW-1:0] w_imem_addr,
    input  logic [31:0]        w_imem_data,
    input  logic               w_redirect,
    input  logic [31:0]        w_redirect_pc,
    output logic               w_out_valid,
    input  logic               w_out_ready,
    output logic [31:0]        w_out_inst,
    output logic [31:0]        w_out_pc
);
    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_q_inst [2];
    logic [31:0] r_q_pc   [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        pop;
    logic        push;
    logic        issue;
    logic        wr_idx;
    logic [1:0]  occ;

    assign pop    = w_out_valid & w_out_ready;
    assign push   = r_inflight;
    assign wr_idx = r_head ^ r_count[0];

    // Occupancy the queue will have after this cycle's pop, counting
    // the word still on its way back from imem.
    assign occ = r_count + {1'b0, r_inflight} - {1'b0, pop};

    assign issue = !w_rst && !w_redirect
                && (r_state == S_RUN) && (occ < 2'd2);

    assign w_imem_en   = issue;
    assign w_imem_addr = r_pc[IMEM_AW+1:2];

    assign w_out_valid = !w_rst && (r_count != 2'd0);
    assign w_out_inst  = w_rst ? 32'h0 : r_q_inst[r_head];
    assign w_out_pc    = w_rst ? 32'h0 : r_q_pc[r_head];

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC & 32'hFFFF_FFFC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_q_inst[0]   <= 32'h0;
            r_q_inst[1]   <= 32'h0;
            r_q_pc[0]     <= 32'h0;
            r_q_pc[1]     <= 32'h0;
        end else if (w_redirect) begin
            r_state    <= S_RUN;
            r_pc       <= w_redirect_pc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state    <= S_RUN;
            r_inflight <= issue;
            if (issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
            if (push) begin
                r_q_inst[wr_idx] <= w_imem_data;
                r_q_pc[wr_idx]   <= r_inflight_pc;
            end
            if (pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_m_fetch.sv
// tb_m_fetch: scoreboard bench for m_fetch with a synchronous imem model
// returning 0x1000 + word address.
module tb_m_fetch;
    logic        w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic        w_rst = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_out_ready = 1'b0;
    logic        w_imem_en;
    logic [5:0]  w_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_out_valid;
    logic [31:0] w_out_inst;
    logic [31:0] w_out_pc;

    logic        w2_rst = 1'b1;
    logic        w2_imem_en;
    logic [5:0]  w2_imem_addr;
    logic [31:0] w2_imem_data;
    logic        w2_out_valid;
    logic        w2_out_ready = 1'b1;
    logic [31:0] w2_out_inst;
    logic [31:0] w2_out_pc;

    m_fetch #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_imem_en(w_imem_en), .w_imem_addr(w_imem_addr),
        .w_imem_data(w_imem_data),
        .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
        .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
        .w_out_inst(w_out_inst), .w_out_pc(w_out_pc)
    );

    m_fetch #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(6)) u_wrap (
        .w_clk(w_clk), .w_rst(w2_rst),
        .w_imem_en(w2_imem_en), .w_imem_addr(w2_imem_addr),
        .w_imem_data(w2_imem_data),
        .w_redirect(1'b0), .w_redirect_pc(32'h0),
        .w_out_valid(w2_out_valid), .w_out_ready(w2_out_ready),
        .w_out_inst(w2_out_inst), .w_out_pc(w2_out_pc)
    );

    // Synchronous imem; poison value when no request was made
    always @(posedge w_clk) begin
        w_imem_data  <= w_imem_en ? 32'h1000 + {26'b0, w_imem_addr}
                                  : 32'hDEAD_BEEF;
        w2_imem_data <= w2_imem_en ? 32'h1000 + {26'b0, w2_imem_addr}
                                   : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t sb_w[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   first;
    int   npops;

    function automatic exp_t model(input logic [31:0] pc);
        exp_t r;
        r.pc   = pc;
        r.inst = 32'h1000 + {26'b0, pc[7:2]};
        return r;
    endfunction

    task automatic fill(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) sb.push_back(model(pc0 + 32'(4 * i)));
    endtask

    // A word returning while two are already buffered would overflow
    always @(posedge w_clk) begin
        if (dut.r_inflight === 1'b1 && dut.r_count === 2'd2) begin
            $display("FAIL fifo_overflow: push into full queue at %0t", $time);
            n_fails++;
        end
    end

    task automatic test_reset();
        @(negedge w_clk);
        w_rst = 1'b1; w_redirect = 1'b0; w_out_ready = 1'b1; #1;
        n_checks++;
        if (w_out_valid !== 1'b0 || w_imem_en !== 1'b0
            || w_out_inst !== 32'h0 || w_out_pc !== 32'h0) begin
            $display("FAIL reset_outputs: valid=%b en=%b inst=%h pc=%h, want 0 0 0 0",
                     w_out_valid, w_imem_en, w_out_inst, w_out_pc);
            n_fails++;
        end
        sb.delete();
        @(negedge w_clk);
        w_rst = 1'b0; #1;
        n_checks++;
        if (w_out_valid !== 1'b0 || w_imem_en !== 1'b0) begin
            $display("FAIL boot_idle: valid=%b en=%b, want 0 0", w_out_valid, w_imem_en);
            n_fails++;
        end
    endtask

    task automatic test_stream();
        fill(32'h0, 16);
        first = -1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b1; #1;
            if (w_out_valid === 1'b1 && first < 0) first = c;
            if (c >= 3) begin
                n_checks++;
                if (w_out_valid !== 1'b1) begin
                    $display("FAIL stream_bubble: cycle %0d valid=%b, want 1", c, w_out_valid);
                    n_fails++;
                end
            end
            if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL stream_pop: got pc=%h, want nothing", w_out_pc);
                    n_fails++;
                end else begin
                    e = sb.pop_front();
                    if (w_out_pc !== e.pc || w_out_inst !== e.inst) begin
                        $display("FAIL stream_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 w_out_pc, w_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
        n_checks++;
        if (first != 3) begin
            $display("FAIL stream_latency: first valid cycle %0d, want 3", first);
            n_fails++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge w_clk);
        n_checks++;
        if (w_out_pc !== 32'd20) begin
            $display("FAIL mid_head: pc=%h, want 00000014", w_out_pc);
            n_fails++;
        end
        w_rst = 1'b1; #1;
        sb.delete();
        @(negedge w_clk);
        w_rst = 1'b0; #1;
        n_checks++;
        if (w_out_valid !== 1'b0 || w_imem_en !== 1'b0) begin
            $display("FAIL mid_reset_flush: valid=%b en=%b, want 0 0", w_out_valid, w_imem_en);
            n_fails++;
        end
        fill(32'h0, 16);
        first = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b1; #1;
            if (w_out_valid === 1'b1 && first < 0) first = c;
            if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL mid_pop: got pc=%h, want nothing", w_out_pc);
                    n_fails++;
                end else begin
                    e = sb.pop_front();
                    if (w_out_pc !== e.pc || w_out_inst !== e.inst) begin
                        $display("FAIL mid_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 w_out_pc, w_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
        n_checks++;
        if (first != 3) begin
            $display("FAIL mid_latency: first valid cycle %0d, want 3", first);
            n_fails++;
        end
    endtask

    task automatic test_backpressure();
        for (int c = 1; c <= 5; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b0; #1;
            n_checks++;
            if (w_out_valid !== 1'b1 || w_out_pc !== 32'd8 || w_out_inst !== 32'h1002) begin
                $display("FAIL bp_hold: valid=%b pc=%h inst=%h, want 1 00000008 00001002",
                         w_out_valid, w_out_pc, w_out_inst);
                n_fails++;
            end
            n_checks++;
            if (w_imem_en !== 1'b0) begin
                $display("FAIL bp_fetch_stop: cycle %0d en=%b, want 0", c, w_imem_en);
                n_fails++;
            end
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b1; #1;
            n_checks++;
            if (w_out_valid !== 1'b1) begin
                $display("FAIL bp_release: cycle %0d valid=%b, want 1", c, w_out_valid);
                n_fails++;
            end
            if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL bp_pop: got pc=%h, want nothing", w_out_pc);
                    n_fails++;
                end else begin
                    e = sb.pop_front();
                    if (w_out_pc !== e.pc || w_out_inst !== e.inst) begin
                        $display("FAIL bp_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 w_out_pc, w_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
    endtask

    // Runs n cycles with ready=1 after a redirect; checks first-valid timing
    task automatic run_after_redirect(input string tag, input int n,
                                      input logic [5:0] want_addr);
        first = -1;
        npops = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge w_clk);
            w_redirect = 1'b0; w_out_ready = 1'b1; #1;
            if (c == 1) begin
                n_checks++;
                if (w_out_valid !== 1'b0 || w_imem_en !== 1'b1 || w_imem_addr !== want_addr) begin
                    $display("FAIL %s_first_fetch: valid=%b en=%b addr=%0d, want 0 1 %0d",
                             tag, w_out_valid, w_imem_en, w_imem_addr, want_addr);
                    n_fails++;
                end
            end
            if (w_out_valid === 1'b1 && first < 0) first = c;
            if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
                npops++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL %s_pop: got pc=%h, want nothing", tag, w_out_pc);
                    n_fails++;
                end else begin
                    e = sb.pop_front();
                    if (w_out_pc !== e.pc || w_out_inst !== e.inst) begin
                        $display("FAIL %s_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 tag, w_out_pc, w_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
        n_checks++;
        if (first != 3 || npops != n - 2) begin
            $display("FAIL %s_latency: first=%0d pops=%0d, want 3 %0d", tag, first, npops, n - 2);
            n_fails++;
        end
    endtask

    task automatic test_redirect();
        @(negedge w_clk);
        w_rst = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        sb.delete();
        fill(32'h0, 2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b1;
            if (c == 4) begin
                w_redirect = 1'b1; w_redirect_pc = 32'h43;
            end
            #1;
            if (c == 4) begin
                n_checks++;
                if (w_imem_en !== 1'b0 || w_out_pc !== 32'd4) begin
                    $display("FAIL redir_cycle: en=%b head=%h, want 0 00000004", w_imem_en, w_out_pc);
                    n_fails++;
                end
            end
            if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL redir_pre_pop: got pc=%h, want nothing", w_out_pc);
                    n_fails++;
                end else begin
                    e = sb.pop_front();
                    if (w_out_pc !== e.pc || w_out_inst !== e.inst) begin
                        $display("FAIL redir_pre_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 w_out_pc, w_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
        sb.delete();
        fill(32'h40, 8);
        run_after_redirect("redir", 6, 6'h10);
    endtask

    task automatic test_redirect_full();
        for (int c = 1; c <= 3; c++) begin
            @(negedge w_clk);
            w_out_ready = 1'b0; #1;
        end
        n_checks++;
        if (w_out_valid !== 1'b1 || w_imem_en !== 1'b0 || w_out_pc !== sb[0].pc) begin
            $display("FAIL full_state: valid=%b en=%b pc=%h, want 1 0 %h",
                     w_out_valid, w_imem_en, w_out_pc, sb[0].pc);
            n_fails++;
        end
        @(negedge w_clk);
        w_redirect = 1'b1; w_redirect_pc = 32'h89; w_out_ready = 1'b0; #1;
        n_checks++;
        if (w_imem_en !== 1'b0) begin
            $display("FAIL full_redir_en: en=%b, want 0", w_imem_en);
            n_fails++;
        end
        sb.delete();
        fill(32'h88, 8);
        run_after_redirect("full", 7, 6'h22);
    endtask

    task automatic test_back_to_back();
        @(negedge w_clk);
        w_redirect = 1'b1; w_redirect_pc = 32'h10; w_out_ready = 1'b0; #1;
        @(negedge w_clk);
        w_redirect = 1'b1; w_redirect_pc = 32'h24; #1;
        n_checks++;
        if (w_out_valid !== 1'b0 || w_imem_en !== 1'b0) begin
            $display("FAIL b2b_flush: valid=%b en=%b, want 0 0", w_out_valid, w_imem_en);
            n_fails++;
        end
        sb.delete();
        fill(32'h24, 8);
        run_after_redirect("b2b", 6, 6'h09);
    endtask

    task automatic test_wrap();
        logic [5:0] exp_addr [3];
        int k;
        exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0;
        k = 0;
        for (int i = 0; i < 8; i++) sb_w.push_back(model(32'hFFFF_FFF8 + 32'(4 * i)));
        @(negedge w_clk);
        w2_rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge w_clk);
            #1;
            if (w2_imem_en === 1'b1) begin
                if (k < 3) begin
                    n_checks++;
                    if (w2_imem_addr !== exp_addr[k]) begin
                        $display("FAIL wrap_addr: fetch %0d addr=%0d, want %0d",
                                 k, w2_imem_addr, exp_addr[k]);
                        n_fails++;
                    end
                end
                k++;
            end
            if (w2_out_valid === 1'b1 && w2_out_ready === 1'b1) begin
                n_checks++;
                if (sb_w.size() == 0) begin
                    $display("FAIL wrap_pop: got pc=%h, want nothing", w2_out_pc);
                    n_fails++;
                end else begin
                    e = sb_w.pop_front();
                    if (w2_out_pc !== e.pc || w2_out_inst !== e.inst) begin
                        $display("FAIL wrap_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                                 w2_out_pc, w2_out_inst, e.pc, e.inst);
                        n_fails++;
                    end
                end
            end
        end
        n_checks++;
        if (sb_w.size() != 2 || k < 3) begin
            $display("FAIL wrap_count: left=%0d fetches=%0d, want 2 >=3", sb_w.size(), k);
            n_fails++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_mid();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
